// File: rtl/cover_sched_pkg.sv
// Shared types and constants for the toggle-valid cover event scheduler.
package cover_sched_pkg;

    // Output-side FSM: EMPTY has no event presented, HOLD presents one.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } sched_state_t;

    // Global cover point index as seen by the sink.
    typedef logic [63:0] cover_index_t;

    // Saturation ceiling for the coalesced-event counter.
    localparam logic [31:0] MERGED_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/cover_rr_arb.sv
// Round-robin arbiter over requester groups.
// The search starts at the group after the last grant and wraps to 0;
// after reset group 0 has first priority.
module cover_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_req
);
    import cover_sched_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] gidx;
    logic          found;

    // Rotated priority search starting at ptr_reg; first requester wins.
    always_comb begin
        logic [PW:0] idx_wide;
        grant    = '0;
        gidx     = '0;
        found    = 1'b0;
        idx_wide = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_wide = {1'b0, ptr_reg} + (PW+1)'(i);
            if (idx_wide >= (PW+1)'(NUM_REQ)) begin
                idx_wide = idx_wide - (PW+1)'(NUM_REQ);
            end
            if (!found && req[idx_wide[PW-1:0]]) begin
                found                   = 1'b1;
                gidx                    = idx_wide[PW-1:0];
                grant[idx_wide[PW-1:0]] = 1'b1;
            end
        end
    end

    assign any_req = found;

    // Next start point is the group after the one granted, wrapping.
    always_comb begin
        ptr_next = ptr_reg;
        if (advance && found) begin
            ptr_next = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // Pointer register, cleared so group 0 is searched first.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/cover_toggle_sched.sv
// Toggle-valid cover event scheduler: latches valid pulses into a pending
// bitmap and presents them one at a time on a valid/ready output.
// Optional feature macro: COVER_TOGGLE_DEDUP_EN (report each point once
// between resets).
module cover_toggle_sched
    import cover_sched_pkg::*;
#(
    parameter int      NUM_GROUPS  = 4,
    parameter int      GROUP_WIDTH = 9,
    parameter longint  COVER_INDEX = 0,
    parameter longint  COVER_TOTAL = 8065
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_GROUPS*GROUP_WIDTH-1:0] valid,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [63:0]                       out_index,
    output logic [31:0]                       merged_cnt,
    output logic                              busy
);
    localparam int NB = NUM_GROUPS * GROUP_WIDTH;
    localparam int BW = (GROUP_WIDTH > 1) ? $clog2(GROUP_WIDTH) : 1;
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    // Index range must fit inside the cover space.
    if (COVER_INDEX + longint'(NB) > COVER_TOTAL) begin : g_bad_cfg
        $error("cover_toggle_sched: COVER_INDEX+NUM_GROUPS*GROUP_WIDTH exceeds COVER_TOTAL");
    end

    sched_state_t       state_reg, state_next;
    logic [NB-1:0]      pending_reg, pending_next;
    cover_index_t       out_index_reg, out_index_next;
    logic [31:0]        merged_cnt_reg, merged_cnt_next;

    logic [NUM_GROUPS-1:0]  group_req;
    logic [NUM_GROUPS-1:0]  group_grant;
    logic                   any_pending;
    logic                   load;
    logic [GROUP_WIDTH-1:0] grp_bits;
    logic [GROUP_WIDTH-1:0] bit_onehot;
    logic [GW-1:0]          sel_group;
    logic [BW-1:0]          sel_bit;
    logic [NB-1:0]          clear_vec;
    logic [NB-1:0]          accept_vec;
    logic [NB-1:0]          merge_vec;

    // Per-group request is the OR of its pending bits.
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_req
        assign group_req[gi] = |pending_reg[gi*GROUP_WIDTH +: GROUP_WIDTH];
    end

    cover_rr_arb #(
        .NUM_REQ (NUM_GROUPS)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (group_req),
        .advance (load),
        .grant   (group_grant),
        .any_req (any_pending)
    );

    // A new event is loaded whenever the output slot is free or being freed.
    assign load = any_pending && ((state_reg == ST_EMPTY) || out_ready);

    // Select the granted group's pending bits and its binary group number.
    always_comb begin
        grp_bits  = '0;
        sel_group = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (group_grant[g]) begin
                grp_bits  = pending_reg[g*GROUP_WIDTH +: GROUP_WIDTH];
                sel_group = GW'(g);
            end
        end
    end

    // Lowest pending bit of the granted group, one-hot and binary.
    assign bit_onehot = grp_bits & (~grp_bits + GROUP_WIDTH'(1));

    always_comb begin
        sel_bit = '0;
        for (int b = GROUP_WIDTH - 1; b >= 0; b--) begin
            if (grp_bits[b]) begin
                sel_bit = BW'(b);
            end
        end
    end

    // Clear mask for the single bit being handed to the output register.
    for (genvar gi = 0; gi < NB; gi++) begin : g_clr
        assign clear_vec[gi] = load && group_grant[gi / GROUP_WIDTH]
                               && bit_onehot[gi % GROUP_WIDTH];
    end

`ifdef COVER_TOGGLE_DEDUP_EN
    logic [NB-1:0] seen_reg;

    // Points already reported since reset are dropped at the input.
    assign accept_vec = valid & ~seen_reg;

    // Seen bitmap records every point loaded into the output register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_reg <= '0;
        end else begin
            seen_reg <= seen_reg | clear_vec;
        end
    end
`else
    assign accept_vec = valid;
`endif

    // A hit on a bit that stays pending is a coalesced event; a hit on a
    // bit being granted re-arms it instead (set wins over clear).
    assign merge_vec    = accept_vec & pending_reg & ~clear_vec;
    assign pending_next = (pending_reg & ~clear_vec) | accept_vec;

    // Saturating add of the number of coalesced events this cycle.
    always_comb begin
        logic [32:0] sum;
        sum = {1'b0, merged_cnt_reg};
        for (int i = 0; i < NB; i++) begin
            if (merge_vec[i]) begin
                sum = sum + 33'd1;
            end
        end
        merged_cnt_next = sum[32] ? MERGED_CNT_MAX : sum[31:0];
    end

    // Output FSM and index register next-state.
    always_comb begin
        state_next     = state_reg;
        out_index_next = out_index_reg;
        if (load) begin
            state_next     = ST_HOLD;
            out_index_next = cover_index_t'(COVER_INDEX)
                           + cover_index_t'(sel_group) * cover_index_t'(GROUP_WIDTH)
                           + cover_index_t'(sel_bit);
        end else if ((state_reg == ST_HOLD) && out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    // State registers; reset drops any held event without a handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ST_EMPTY;
            pending_reg    <= '0;
            out_index_reg  <= '0;
            merged_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            out_index_reg  <= out_index_next;
            merged_cnt_reg <= merged_cnt_next;
        end
    end

    assign out_valid  = (state_reg == ST_HOLD);
    assign out_index  = out_index_reg;
    assign merged_cnt = merged_cnt_reg;
    assign busy       = (|pending_reg) || out_valid;

endmodule
